// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the single-cycle MIPS core slice.
// Contents:
//   - IMEM_BYTES: instruction memory size in bytes, also used by the loader.
//   - LOADER_SYNC_BYTE: default frame start marker for the boot loader.
//   - loader_state_t: the boot-loader FSM states.
//   - frame_payload_bytes(): converts a 16-bit word count into a byte count.
package mips_pkg;

  localparam int unsigned IMEM_BYTES = 1024;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  // Converts a word count into a byte count. The result is 20 bits wide so
  // that later base-address additions cannot wrap.
  function automatic logic [19:0] frame_payload_bytes(input logic [15:0] words);
    return {2'b00, words, 2'b00};
  endfunction

endpackage

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: boot loader that fills the byte-addressed instruction
// memory from a framed byte stream. It holds the CPU in reset until a
// complete image with a matching checksum has been written.
//
// Frame format: SYNC, CNT_LO, CNT_HI, 4*N payload bytes, CHK.
//   - N is a 16-bit word count.
//   - Payload byte k is written to BASE_ADDR+k.
//   - CHK is the XOR of all payload bytes.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   in_valid   in   stream byte valid
//   in_data    in   stream byte
//   in_ready   out  always 1; the loader never back-pressures
//   mem_we     out  imem byte write strobe, one cycle per payload byte
//   mem_addr   out  imem byte address
//   mem_wdata  out  imem byte data
//   cpu_hold   out  high while no valid image is loaded
//   load_done  out  high once the checksum has matched
//   load_error out  sticky error flag, cleared by SYNC or reset
//   byte_cnt   out  payload bytes written in the current frame
module imem_stream_loader
  import mips_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   byte_cnt
);

  loader_state_t     r_state, w_state_nxt;
  logic [7:0]        r_cnt_lo, w_cnt_lo_nxt;
  logic [19:0]       r_total, w_total_nxt;
  logic [7:0]        r_chk, w_chk_nxt;
  logic [ADDR_W:0]   r_byte_cnt, w_byte_cnt_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_load_done, w_load_done_nxt;
  logic              r_load_error, w_load_error_nxt;

  logic [19:0]       w_frame_bytes;
  logic [19:0]       w_frame_end;
  logic [ADDR_W:0]   w_byte_cnt_inc;
  logic              w_is_sync;

  // The frame end is evaluated in 20 bits, so a huge N cannot wrap past
  // the memory size and slip through the overflow check.
  assign w_frame_bytes  = frame_payload_bytes({in_data, r_cnt_lo});
  assign w_frame_end    = 20'(BASE_ADDR) + w_frame_bytes;
  assign w_byte_cnt_inc = r_byte_cnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_is_sync      = (in_data == SYNC_BYTE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the datapath updates for each accepted byte
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_lo_nxt     = r_cnt_lo;
    w_total_nxt      = r_total;
    w_chk_nxt        = r_chk;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_cpu_hold_nxt   = r_cpu_hold;
    w_load_done_nxt  = r_load_done;
    w_load_error_nxt = r_load_error;

    if (in_valid) begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // A new frame re-asserts the hold. The CPU stays in reset even
          // when a running image is being replaced.
          if (w_is_sync) begin
            w_state_nxt      = ST_CNT_LO;
            w_byte_cnt_nxt   = '0;
            w_chk_nxt        = 8'h00;
            w_load_error_nxt = 1'b0;
            w_load_done_nxt  = 1'b0;
            w_cpu_hold_nxt   = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_CNT_LO: begin
          w_cnt_lo_nxt = in_data;
          w_state_nxt  = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          w_total_nxt = w_frame_bytes;
          if (w_frame_bytes == 20'd0) begin
            w_state_nxt = ST_CHK;
          end else if (w_frame_end > 20'(MEM_BYTES)) begin
            w_state_nxt      = ST_ERR;
            w_load_error_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = ADDR_W'(BASE_ADDR) + r_byte_cnt[ADDR_W-1:0];
          w_mem_wdata_nxt = in_data;
          w_chk_nxt       = r_chk ^ in_data;
          w_byte_cnt_nxt  = w_byte_cnt_inc;
          if ({{(19 - ADDR_W){1'b0}}, w_byte_cnt_inc} == r_total) begin
            w_state_nxt = ST_CHK;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_CHK: begin
          if (in_data == r_chk) begin
            w_state_nxt     = ST_DONE;
            w_cpu_hold_nxt  = 1'b0;
            w_load_done_nxt = 1'b1;
          end else begin
            w_state_nxt      = ST_ERR;
            w_load_error_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_lo     <= 8'h00;
      r_total      <= 20'd0;
      r_chk        <= 8'h00;
      r_byte_cnt   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_cnt_lo     <= w_cnt_lo_nxt;
      r_total      <= w_total_nxt;
      r_chk        <= w_chk_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_cpu_hold   <= w_cpu_hold_nxt;
      r_load_done  <= w_load_done_nxt;
      r_load_error <= w_load_error_nxt;
    end
  end

  assign in_ready   = 1'b1;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;
  assign byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed self-checking bench for imem_stream_loader.
// A shadow memory captures every write strobe. Each scenario task compares
// the DUT outputs and the shadow memory against values that the bench
// builds itself.
module tb_imem_stream_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;
  logic [10:0] byte_cnt;

  int pass_cnt;
  int total_cnt;
  int we_cnt;
  int last_addr;
  logic [7:0] tb_mem  [0:1023];
  logic [7:0] payload [0:1023];

  imem_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_cnt   (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow imem: captures the registered write port at each rising edge.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] = mem_wdata;
      we_cnt = we_cnt + 1;
      last_addr = int'(mem_addr);
    end
  end

  // Sum of 1..10 into $s1, then $s7 = 777.
  task automatic load_program();
    logic [31:0] prog [0:10];
    prog[0]  = 32'h20100001;
    prog[1]  = 32'h20110000;
    prog[2]  = 32'h2012000B;
    prog[3]  = 32'h02308820;
    prog[4]  = 32'h22100001;
    prog[5]  = 32'h1612FFFD;
    prog[6]  = 32'h00000000;
    prog[7]  = 32'h20170309;
    prog[8]  = 32'h1000FFFF;
    prog[9]  = 32'h00000000;
    prog[10] = 32'h00000000;
    for (int w = 0; w < 11; w++) begin
      for (int b = 0; b < 4; b++) begin
        payload[w*4+b] = prog[w][b*8 +: 8];
      end
    end
  endtask

  // Drives one byte. With gaps set, it inserts idle cycles first and puts
  // a SYNC value on the bus while in_valid is low.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input int n_words, input bit bad_chk, input bit gaps);
    logic [7:0] chk;
    logic [15:0] n16;
    n16 = 16'(n_words);
    chk = 8'h00;
    send_byte(8'hA5, gaps);
    send_byte(n16[7:0], gaps);
    send_byte(n16[15:8], gaps);
    for (int k = 0; k < n_words * 4; k++) begin
      send_byte(payload[k], gaps);
      chk = chk ^ payload[k];
    end
    send_byte(bad_chk ? ~chk : chk, gaps);
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 1024; i++) tb_mem[i] = 8'hxx;
    we_cnt = 0;
    last_addr = -1;
  endtask

  task automatic check_mem(input string name, input int nbytes);
    int bad;
    bad = 0;
    for (int i = 0; i < nbytes; i++) begin
      if (tb_mem[i] !== payload[i]) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL %s: %0d bytes differ, required 0", name, bad);
    else pass_cnt++;
  endtask

  task automatic check_reset_values(input string name);
    total_cnt++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, byte_cnt}
        !== {1'b1, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 1'b0, 11'd0})
      $display("FAIL %s: rdy=%b we=%b addr=%0d wd=%h hold=%b done=%b err=%b cnt=%0d, required 1 0 0 00 1 0 0 0",
               name, in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, byte_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    load_program();
    clear_shadow();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    total_cnt++;
    if (we_cnt !== 0 || cpu_hold !== 1'b1) $display("FAIL garbage: writes=%0d hold=%b, required 0 1", we_cnt, cpu_hold);
    else pass_cnt++;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 44; k++) send_byte(payload[k], 1'b0);
    total_cnt++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) $display("FAIL hold_before_chk: hold=%b done=%b, required 1 0", cpu_hold, load_done);
    else pass_cnt++;
    begin
      logic [7:0] chk;
      chk = 8'h00;
      for (int k = 0; k < 44; k++) chk = chk ^ payload[k];
      send_byte(chk, 1'b0);
    end
    total_cnt++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b1 || load_error !== 1'b0)
      $display("FAIL release_after_chk: hold=%b done=%b err=%b, required 0 1 0", cpu_hold, load_done, load_error);
    else pass_cnt++;
    total_cnt++;
    if (we_cnt !== 44 || last_addr !== 43) $display("FAIL load_writes: count=%0d last=%0d, required 44 43", we_cnt, last_addr);
    else pass_cnt++;
    total_cnt++;
    if ({tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]} !== 32'h01001020)
      $display("FAIL first_word: got %h%h%h%h, required 01001020", tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]);
    else pass_cnt++;
    total_cnt++;
    if (byte_cnt !== 11'd44 || mem_we !== 1'b0) $display("FAIL load_cnt: cnt=%0d we=%b, required 44 0", byte_cnt, mem_we);
    else pass_cnt++;
    check_mem("load_image", 44);
  endtask

  task automatic test_bad_chk();
    clear_shadow();
    send_frame(11, 1'b1, 1'b0);
    total_cnt++;
    if (load_error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0)
      $display("FAIL bad_chk: err=%b hold=%b done=%b, required 1 1 0", load_error, cpu_hold, load_done);
    else pass_cnt++;
    send_frame(11, 1'b0, 1'b0);
    total_cnt++;
    if (load_error !== 1'b0 || cpu_hold !== 1'b0 || load_done !== 1'b1)
      $display("FAIL resend: err=%b hold=%b done=%b, required 0 0 1", load_error, cpu_hold, load_done);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    clear_shadow();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    // Bytes that would be payload must be dropped in ERR.
    for (int k = 0; k < 8; k++) send_byte(8'(k), 1'b0);
    total_cnt++;
    if (load_error !== 1'b1 || we_cnt !== 0 || cpu_hold !== 1'b1)
      $display("FAIL overflow: err=%b writes=%0d hold=%b, required 1 0 1", load_error, we_cnt, cpu_hold);
    else pass_cnt++;
    for (int k = 0; k < 1024; k++) payload[k] = 8'((k * 7 + 3) ^ (k >> 8));
    clear_shadow();
    send_frame(256, 1'b0, 1'b0);
    total_cnt++;
    if (we_cnt !== 1024 || last_addr !== 1023 || load_done !== 1'b1 || byte_cnt !== 11'd1024)
      $display("FAIL full_mem: writes=%0d last=%0d done=%b cnt=%0d, required 1024 1023 1 1024",
               we_cnt, last_addr, load_done, byte_cnt);
    else pass_cnt++;
    check_mem("full_mem_image", 1024);
  endtask

  task automatic test_gaps();
    load_program();
    clear_shadow();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    send_frame(11, 1'b0, 1'b1);
    total_cnt++;
    if (we_cnt !== 44 || last_addr !== 43 || load_done !== 1'b1)
      $display("FAIL gaps: writes=%0d last=%0d done=%b, required 44 43 1", we_cnt, last_addr, load_done);
    else pass_cnt++;
    check_mem("gaps_image", 44);
  endtask

  task automatic test_reset_mid();
    clear_shadow();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 10; k++) send_byte(payload[k], 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("reset_mid_frame");
    reset = 1'b1;
    total_cnt++;
    if (we_cnt !== 10) $display("FAIL partial_writes: writes=%0d, required 10", we_cnt);
    else pass_cnt++;
    clear_shadow();
    send_frame(11, 1'b0, 1'b0);
    total_cnt++;
    if (load_done !== 1'b1 || we_cnt !== 44) $display("FAIL reload: done=%b writes=%0d, required 1 44", load_done, we_cnt);
    else pass_cnt++;
    check_mem("reload_image", 44);
    clear_shadow();
    send_frame(0, 1'b0, 1'b0);
    total_cnt++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || we_cnt !== 0 || byte_cnt !== 11'd0)
      $display("FAIL empty_frame: done=%b hold=%b writes=%0d cnt=%0d, required 1 0 0 0",
               load_done, cpu_hold, we_cnt, byte_cnt);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    we_cnt    = 0;
    last_addr = -1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_bad_chk();
    test_overflow();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware boot loader for the single-cycle MIPS core's byte-addressed instruction memory.
- Receives a framed byte stream on a valid/ready interface, for example from a UART receiver or a debug port.
- Writes the stream into imem as little-endian bytes, one byte per cycle, and holds the CPU in reset until a complete, checksum-valid image has landed.
- Replaces simulation-only backdoor writes with a synthesizable loading path that sits beside the instruction memory in the top module.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; must be a power of two.
- ADDR_W, 10, byte address width; equals log2(MEM_BYTES).
- BASE_ADDR, 0, byte address of the first loaded byte; must be 4-aligned.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on a cycle where in_valid && in_ready.
- mem_we  out  1  imem byte write strobe.
- mem_addr  out  ADDR_W  imem byte address.
- mem_wdata  out  8  imem byte data.
- cpu_hold  out  1  drives the CPU reset; high while no valid image is loaded.
- load_done  out  1  high once the checksum has matched; cleared when a new frame starts.
- load_error  out  1  sticky until the next SYNC byte or reset.
- byte_cnt  out  ADDR_W+1  payload bytes written in the current frame (debug).

Behaviour:
- Frame format: SYNC, CNT_LO, CNT_HI, then 4*N payload bytes, then CHK.
  - N is a 16-bit word count.
  - Payload bytes are sent LSB first per word, so byte k goes to BASE_ADDR+k.
  - CHK is the XOR of all payload bytes.
- Reset (reset==0 at a posedge) forces:
  - state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0;
  - cpu_hold=1, load_done=0, load_error=0;
  - byte_cnt=0, checksum accumulator=0.
  - Reset mid-frame abandons the frame. Bytes already written remain in imem.
- States:
  - IDLE: an accepted byte equal to SYNC_BYTE -> CNT_LO, clearing byte_cnt, accumulator and load_error. Any other byte is discarded.
  - CNT_LO: latch count[7:0] -> CNT_HI.
  - CNT_HI: latch count[15:8].
    - If N == 0 -> CHK.
    - If BASE_ADDR + 4*N > MEM_BYTES (computed in 18+ bits, no wrap) -> ERR.
    - Otherwise -> DATA.
  - DATA: each accepted byte is written and XORed into the accumulator, and byte_cnt increments. After byte 4*N-1 -> CHK.
  - CHK:
    - Accepted byte == accumulator -> DONE: cpu_hold=0, load_done=1.
    - Mismatch -> ERR: load_error=1, cpu_hold stays 1.
  - DONE: in_ready=1. An accepted SYNC_BYTE sets cpu_hold=1 and load_done=0, then -> CNT_LO (reload). Other bytes are discarded, and the CPU keeps running.
  - ERR: in_ready=1. Bytes are discarded until SYNC_BYTE, which -> CNT_LO.
- Write timing: registered, with latency 1.
  - A data byte accepted at edge t produces mem_we=1, mem_addr=BASE_ADDR+byte_cnt(old) and mem_wdata=byte during the cycle after t.
  - mem_we is a single-cycle pulse per byte. Back-to-back bytes give back-to-back writes.
- cpu_hold and load_done change on the edge that accepts CHK. They change only after the last payload write has been issued, so the write of the last byte and the release of cpu_hold land in the same cycle at the earliest.
- in_ready is 1 in every state; the loader never back-pressures.
- in_valid==0 stalls the FSM with no state change. Gaps of any length are legal mid-frame; there is no timeout.
- mem_addr never wraps: the overflow check rejects such frames before any payload write.
- SYNC_BYTE values inside CNT or DATA are treated as data, not resync.

Decomposition:
- Shared package (mips_pkg) holds:
  - loader state enum: IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR;
  - SYNC_BYTE default;
  - IMEM_BYTES constant, shared with the instruction memory.
- No sub-module. The FSM, counters and XOR accumulator live in one module.
- Top-level integration: OR mem_we/mem_addr into the imem write port, and OR cpu_hold into the core reset (translated to the core's reset polarity).

Test Plan:
- Load the 11-word sum-of-1..10 program: A5 0B 00, 44 payload bytes (first word 01 00 10 20), correct CHK.
  - 44 mem_we pulses at addresses 0..43; imem[0..3] = 01,00,10,20.
  - cpu_hold falls one cycle after CHK.
  - The core then reaches $s1=55 and $s7=777.
- Same frame with the CHK byte inverted -> load_error=1, cpu_hold stays 1, load_done=0.
  - Then resend the correct frame -> load_done=1, load_error=0.
- Frame A5 01 01 (N=257, 1028 bytes > 1024) -> ERR with zero mem_we pulses.
  - Frame with N=256 -> last write at address 1023, then DONE.
- Frame with in_valid toggling randomly (50% duty) -> identical imem contents and identical single mem_we per byte.
  - Garbage bytes 00 FF 12 before A5 are ignored.
- Assert reset low after 10 payload bytes -> all outputs return to reset values next cycle.
  - The next full frame loads correctly. A frame with N=0 followed by CHK=00 -> DONE with no writes.
